multicycle_control_fsm: RTL and testbench

//  Main control FSM of the multicycle MIPS datapath; sits directly upstream of register_file.

---
 rtl/multicycle_control_fsm_pkg.sv | 68 ++++++
 rtl/multicycle_control_fsm_decoder.sv | 68 ++++++
 rtl/multicycle_control_fsm.sv | 82 ++++++++
 tb/tb_multicycle_control_fsm.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared control definitions for the multicycle MIPS controller and datapath mux selects:
// opcodes, state encodings, select codes and the control-word struct.
package multicycle_control_fsm_pkg;

  localparam int OPCODE_W = 6;
  localparam int STATE_W  = 4;

  localparam logic [OPCODE_W-1:0] OP_R    = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J    = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_JAL  = 6'h03;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_LW   = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW   = 6'h2B;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALU_WB  = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDI_EX = 4'd9,
    S_ADDI_WB = 4'd10,
    S_JUMP    = 4'd11,
    S_JAL     = 4'd12
  } state_e;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] ALU_SRC_B_REG    = 2'b00;
  localparam logic [1:0] ALU_SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] ALU_SRC_B_IMM    = 2'b10;
  localparam logic [1:0] ALU_SRC_B_IMM_SH = 2'b11;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] MEM_TO_REG_ALU = 2'b00;
  localparam logic [1:0] MEM_TO_REG_MDR = 2'b01;
  localparam logic [1:0] MEM_TO_REG_PC  = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_fsm_decoder.sv
// Moore output decode: state -> control word. JAL state only decoded with MIPS_JAL_EN defined.
module ctrl_output_decoder
  import multicycle_control_fsm_pkg::*;
(
  input  state_e state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = ALU_SRC_B_FOUR;
      end
      S_DECODE:  ctrl.alu_src_b = ALU_SRC_B_IMM_SH;
      S_MEM_ADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_SRC_B_IMM;
      end
      S_MEM_RD:  ctrl.iord = 1'b1;
      S_MEM_WB: begin
        ctrl.mem_to_reg = MEM_TO_REG_MDR;
        ctrl.reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      S_ALU_WB: begin
        ctrl.reg_dst   = REG_DST_RD;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_OP_SUB;
        ctrl.pc_src    = PC_SRC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_SRC_B_IMM;
      end
      S_ADDI_WB: ctrl.reg_write = 1'b1;
      S_JUMP: begin
        ctrl.pc_src   = PC_SRC_JUMP;
        ctrl.pc_write = 1'b1;
      end
`ifdef MIPS_JAL_EN
      // Link and jump in one cycle: PC is written and its old value lands in $31.
      S_JAL: begin
        ctrl.pc_src     = PC_SRC_JUMP;
        ctrl.pc_write   = 1'b1;
        ctrl.reg_dst    = REG_DST_RA;
        ctrl.mem_to_reg = MEM_TO_REG_PC;
        ctrl.reg_write  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS main control FSM: state register, next-state logic, reset-gated Moore outputs.
// Optional JAL support is compiled in with `define MIPS_JAL_EN.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode_i,
  output logic                iord_o,
  output logic                mem_write_o,
  output logic                ir_write_o,
  output logic                pc_write_o,
  output logic                branch_o,
  output logic [1:0]          pc_src_o,
  output logic                alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic [1:0]          alu_op_o,
  output logic [1:0]          reg_dst_o,
  output logic [1:0]          mem_to_reg_o,
  output logic                reg_write_o,
  output logic [STATE_W-1:0]  state_o
);

  state_e state, state_n;
  ctrl_t  dec, ctrl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_n;
  end

  always_comb begin
    state_n = S_FETCH;
    case (state)
      S_FETCH: state_n = S_DECODE;
      S_DECODE: begin
        if (opcode_i == OPCODE_W'(OP_LW) || opcode_i == OPCODE_W'(OP_SW)) state_n = S_MEM_ADR;
        else if (opcode_i == OPCODE_W'(OP_R))    state_n = S_EXECUTE;
        else if (opcode_i == OPCODE_W'(OP_BEQ))  state_n = S_BRANCH;
        else if (opcode_i == OPCODE_W'(OP_J))    state_n = S_JUMP;
        else if (opcode_i == OPCODE_W'(OP_ADDI)) state_n = S_ADDI_EX;
`ifdef MIPS_JAL_EN
        else if (opcode_i == OPCODE_W'(OP_JAL))  state_n = S_JAL;
`endif
      end
      S_MEM_ADR: begin
        if (opcode_i == OPCODE_W'(OP_LW))      state_n = S_MEM_RD;
        else if (opcode_i == OPCODE_W'(OP_SW)) state_n = S_MEM_WR;
      end
      S_MEM_RD:  state_n = S_MEM_WB;
      S_EXECUTE: state_n = S_ALU_WB;
      S_ADDI_EX: state_n = S_ADDI_WB;
      default:   state_n = S_FETCH;
    endcase
  end

  ctrl_output_decoder u_dec (
    .state (state),
    .ctrl  (dec)
  );

  // Gate with the raw reset so every strobe drops the instant reset falls, not at the next edge.
  assign ctrl = reset ? dec : '0;

  assign iord_o       = ctrl.iord;
  assign mem_write_o  = ctrl.mem_write;
  assign ir_write_o   = ctrl.ir_write;
  assign pc_write_o   = ctrl.pc_write;
  assign branch_o     = ctrl.branch;
  assign pc_src_o     = ctrl.pc_src;
  assign alu_src_a_o  = ctrl.alu_src_a;
  assign alu_src_b_o  = ctrl.alu_src_b;
  assign alu_op_o     = ctrl.alu_op;
  assign reg_dst_o    = ctrl.reg_dst;
  assign mem_to_reg_o = ctrl.mem_to_reg;
  assign reg_write_o  = ctrl.reg_write;
  assign state_o      = reset ? STATE_W'(state) : '0;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized instruction stream against a per-opcode expected control sequence built from the ISA rules.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode_i;
  logic       iord_o, mem_write_o, ir_write_o, pc_write_o, branch_o;
  logic [1:0] pc_src_o, alu_src_b_o, alu_op_o, reg_dst_o, mem_to_reg_o;
  logic       alu_src_a_o, reg_write_o;
  logic [3:0] state_o;

  int checks = 0;
  int errors = 0;
  logic [20:0] exp_q[$];

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .opcode_i     (opcode_i),
    .iord_o       (iord_o),
    .mem_write_o  (mem_write_o),
    .ir_write_o   (ir_write_o),
    .pc_write_o   (pc_write_o),
    .branch_o     (branch_o),
    .pc_src_o     (pc_src_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_op_o     (alu_op_o),
    .reg_dst_o    (reg_dst_o),
    .mem_to_reg_o (mem_to_reg_o),
    .reg_write_o  (reg_write_o),
    .state_o      (state_o)
  );

  wire [20:0] obs = {state_o, iord_o, mem_write_o, ir_write_o, pc_write_o, branch_o, pc_src_o,
                     alu_src_a_o, alu_src_b_o, alu_op_o, reg_dst_o, mem_to_reg_o, reg_write_o};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // state, iord, mem_write, ir_write, pc_write, branch, pc_src, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write
  function automatic logic [20:0] cw(input int st, input int iord, input int mw, input int irw,
                                     input int pcw, input int br, input int pcs, input int asa,
                                     input int asb, input int aop, input int rd, input int m2r,
                                     input int rw);
    return {4'(st), 1'(iord), 1'(mw), 1'(irw), 1'(pcw), 1'(br), 2'(pcs), 1'(asa), 2'(asb),
            2'(aop), 2'(rd), 2'(m2r), 1'(rw)};
  endfunction

  function automatic logic [20:0] fetch_word();
    return cw(0, 0,0,1,1,0, 0,0,1,0, 0,0,0);
  endfunction

  task automatic model(input logic [5:0] opc);
    exp_q.delete();
    exp_q.push_back(fetch_word());
    exp_q.push_back(cw(1, 0,0,0,0,0, 0,0,3,0, 0,0,0));
    case (opc)
      6'h23: begin
        exp_q.push_back(cw(2, 0,0,0,0,0, 0,1,2,0, 0,0,0));
        exp_q.push_back(cw(3, 1,0,0,0,0, 0,0,0,0, 0,0,0));
        exp_q.push_back(cw(4, 0,0,0,0,0, 0,0,0,0, 0,1,1));
      end
      6'h2B: begin
        exp_q.push_back(cw(2, 0,0,0,0,0, 0,1,2,0, 0,0,0));
        exp_q.push_back(cw(5, 1,1,0,0,0, 0,0,0,0, 0,0,0));
      end
      6'h00: begin
        exp_q.push_back(cw(6, 0,0,0,0,0, 0,1,0,2, 0,0,0));
        exp_q.push_back(cw(7, 0,0,0,0,0, 0,0,0,0, 1,0,1));
      end
      6'h04: exp_q.push_back(cw(8, 0,0,0,0,1, 1,1,0,1, 0,0,0));
      6'h02: exp_q.push_back(cw(11, 0,0,0,1,0, 2,0,0,0, 0,0,0));
      6'h08: begin
        exp_q.push_back(cw(9, 0,0,0,0,0, 0,1,2,0, 0,0,0));
        exp_q.push_back(cw(10, 0,0,0,0,0, 0,0,0,0, 0,0,1));
      end
`ifdef MIPS_JAL_EN
      6'h03: exp_q.push_back(cw(12, 0,0,0,1,0, 2,0,0,0, 2,2,1));
`endif
      default: ;
    endcase
  endtask

  // One register write per LW/R/ADDI(/JAL), one memory write per SW, nothing otherwise.
  function automatic int exp_rw(input logic [5:0] opc);
`ifdef MIPS_JAL_EN
    if (opc == 6'h03) return 1;
`endif
    return (opc == 6'h23 || opc == 6'h00 || opc == 6'h08) ? 1 : 0;
  endfunction

  // Enter at a negedge with the DUT in FETCH; leave at the negedge of the next FETCH.
  task automatic run_instr(input logic [5:0] opc);
    int nrw = 0;
    int nmw = 0;
    opcode_i = opc;
    model(opc);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check($sformatf("op%02h_c%0d", opc, k), {11'd0, obs}, {11'd0, exp_q[k]});
      check($sformatf("op%02h_c%0d_excl", opc, k), {31'd0, reg_write_o & mem_write_o}, 32'd0);
      nrw += int'(reg_write_o);
      nmw += int'(mem_write_o);
      // Opcode is no longer sampled after MEM_ADR; scramble it to prove that.
      if (k == 3) opcode_i = 6'($urandom);
    end
    check($sformatf("op%02h_rw_cnt", opc), nrw, exp_rw(opc));
    check($sformatf("op%02h_mw_cnt", opc), nmw, (opc == 6'h2B) ? 1 : 0);
    @(negedge clk);
  endtask

  initial begin
    logic [5:0] picks[9];
    logic [5:0] opc;
    picks = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h03, 6'h3F, 6'h00};

    reset    = 1'b0;
    opcode_i = 6'h00;
    repeat (3) @(negedge clk);
    #1 check("rst_out", {11'd0, obs}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 check("rst_rel_irw", {31'd0, ir_write_o}, 32'd1);

    run_instr(6'h23);
    run_instr(6'h00);
    run_instr(6'h2B);
    run_instr(6'h04);
    run_instr(6'h02);
    run_instr(6'h3F);
    run_instr(6'h03);
    run_instr(6'h08);

    // Reset mid-LW while in MEM_RD.
    opcode_i = 6'h23;
    repeat (3) @(negedge clk);
    #1 check("mid_memrd", {11'd0, obs}, {11'd0, cw(3, 1,0,0,0,0, 0,0,0,0, 0,0,0)});
    #2 reset = 1'b0;
    #1 check("mid_rst_now", {11'd0, obs}, 32'd0);
    @(negedge clk);
    #1 check("mid_rst_hold", {11'd0, obs}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 check("mid_rst_rel", {11'd0, obs}, {11'd0, fetch_word()});
    run_instr(6'h2B);

    repeat (60) begin
      int sel = int'($urandom_range(0, 9));
      opc = (sel == 9) ? 6'($urandom) : picks[sel];
      run_instr(opc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
